// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_MEM_BUSY,
    ARB_IF_BUSY,
    ARB_MEM_DONE,
    ARB_IF_DONE
  } arb_state_t;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [3:0]  SEL_ALL   = 4'hF;

endpackage

// File: rtl/bus_arbiter_if.sv
// Pipeline-side and bus-side signals of the arbiter; master is the arbiter's view.
interface bus_arbiter_if;

  logic        flush_i;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_stallreq_o;

  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_stallreq_o;

  logic        bus_cyc_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  modport master (
    input  flush_i, if_ce_i, if_addr_i,
    input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    input  bus_data_i, bus_ack_i,
    output if_data_o, if_stallreq_o, mem_data_o, mem_stallreq_o,
    output bus_cyc_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, bus_err_o
  );

  modport slave (
    output flush_i, if_ce_i, if_addr_i,
    output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    output bus_data_i, bus_ack_i,
    input  if_data_o, if_stallreq_o, mem_data_o, mem_stallreq_o,
    input  bus_cyc_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, bus_err_o
  );

endinterface

// File: rtl/bus_arbiter.sv
// Serialises fetch and data accesses onto one memory bus with a one-entry fetch buffer.
// Optional bus timeout abort is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
`ifdef BUS_ARB_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
)
`endif
(
  input logic           clk,
  input logic           rst,
  bus_arbiter_if.master arb
);

  arb_state_t  state;
  logic        buf_valid;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;
  logic [31:0] if_data_q;
  logic        if_discard;
  logic        hit;
  logic        timed_out;
  logic        bus_done;
  logic [31:0] rd_data;

  // A buffer hit returns the stored instruction in the same cycle, so no stall is raised.
  assign hit             = buf_valid && (buf_addr == arb.if_addr_i);
  assign arb.if_data_o   = hit ? buf_data : if_data_q;
  assign arb.mem_stallreq_o = !rst && arb.mem_ce_i && (state != ARB_MEM_DONE);
  assign arb.if_stallreq_o  = !rst && arb.if_ce_i && !hit && (state != ARB_IF_DONE);
  assign bus_done        = arb.bus_ack_i || timed_out;
  assign rd_data         = timed_out ? ZERO_WORD : arb.bus_data_i;

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] timeout_cnt;
  logic       busy;

  assign busy      = (state == ARB_MEM_BUSY) || (state == ARB_IF_BUSY);
  assign timed_out = busy && !arb.bus_ack_i && (timeout_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_cnt   <= 8'd0;
      arb.bus_err_o <= 1'b0;
    end else begin
      arb.bus_err_o <= timed_out;
      timeout_cnt   <= busy ? timeout_cnt + 8'd1 : 8'd0;
    end
  end
`else
  assign timed_out     = 1'b0;
  assign arb.bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ARB_IDLE;
      buf_valid      <= 1'b0;
      buf_addr       <= ZERO_WORD;
      buf_data       <= ZERO_WORD;
      if_data_q      <= ZERO_WORD;
      if_discard     <= 1'b0;
      arb.mem_data_o <= ZERO_WORD;
      arb.bus_cyc_o  <= 1'b0;
      arb.bus_we_o   <= 1'b0;
      arb.bus_sel_o  <= 4'h0;
      arb.bus_addr_o <= ZERO_WORD;
      arb.bus_data_o <= ZERO_WORD;
    end else begin
      if (arb.flush_i) buf_valid <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (arb.mem_ce_i) begin
            arb.bus_cyc_o  <= 1'b1;
            arb.bus_we_o   <= arb.mem_we_i;
            arb.bus_sel_o  <= arb.mem_sel_i;
            arb.bus_addr_o <= arb.mem_addr_i;
            arb.bus_data_o <= arb.mem_data_i;
            state          <= ARB_MEM_BUSY;
          end else if (arb.if_ce_i && !hit) begin
            arb.bus_cyc_o  <= 1'b1;
            arb.bus_we_o   <= 1'b0;
            arb.bus_sel_o  <= SEL_ALL;
            arb.bus_addr_o <= arb.if_addr_i;
            arb.bus_data_o <= ZERO_WORD;
            if_discard     <= arb.flush_i;
            state          <= ARB_IF_BUSY;
          end
        end
        ARB_MEM_BUSY: begin
          if (bus_done) begin
            arb.bus_cyc_o  <= 1'b0;
            arb.mem_data_o <= rd_data;
            state          <= ARB_MEM_DONE;
            if (arb.bus_we_o && buf_valid && (buf_addr == arb.bus_addr_o))
              buf_valid <= 1'b0;
          end
        end
        // A flush seen at any point of the fetch lets the bus cycle finish but drops its data.
        ARB_IF_BUSY: begin
          if (bus_done) begin
            arb.bus_cyc_o <= 1'b0;
            if (if_discard || arb.flush_i) begin
              state <= ARB_IDLE;
            end else begin
              if_data_q <= rd_data;
              state     <= ARB_IF_DONE;
              if (!timed_out) begin
                buf_valid <= 1'b1;
                buf_addr  <= arb.bus_addr_o;
                buf_data  <= rd_data;
              end
            end
          end else if (arb.flush_i) begin
            if_discard <= 1'b1;
          end
        end
        ARB_MEM_DONE: state <= ARB_IDLE;
        ARB_IF_DONE:  state <= ARB_IDLE;
        default:      state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a bus slave model pops expected bus commands as cycles start.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_arbiter_if bif();

  bus_arbiter dut (
    .clk (clk),
    .rst (rst),
    .arb (bif.master)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] data;
  } bus_op_t;

  bus_op_t     exp_bus_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int          check_count = 0;
  int          pass_count  = 0;
  int          extra_cycles = 0;
  int          ack_wait = 0;
  int          wait_cnt = 0;
  bit          cyc_seen = 1'b0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Bus slave: checks each new command against the scoreboard, then acks after ack_wait cycles.
  always @(negedge clk) begin
    if (rst || bif.bus_cyc_o !== 1'b1) begin
      bif.bus_ack_i  = 1'b0;
      bif.bus_data_i = 32'hBAD0_0BAD;
      wait_cnt       = 0;
      cyc_seen       = 1'b0;
    end else begin
      if (!cyc_seen) begin
        bus_op_t op;
        cyc_seen = 1'b1;
        if (exp_bus_q.size() == 0) begin
          extra_cycles++;
          $display("[TB] unexpected bus cycle at %h", bif.bus_addr_o);
        end else begin
          op = exp_bus_q.pop_front();
          checkOutput("bus_addr", bif.bus_addr_o, op.addr);
          checkOutput("bus_we", 32'(bif.bus_we_o), 32'(op.we));
          checkOutput("bus_sel", 32'(bif.bus_sel_o), 32'(op.sel));
          if (op.we) checkOutput("bus_wdata", bif.bus_data_o, op.data);
        end
      end
      if (wait_cnt == ack_wait) begin
        bif.bus_ack_i = 1'b1;
        if (bif.bus_we_o)
          mem_model[bif.bus_addr_o] = merge(mem_read(bif.bus_addr_o), bif.bus_data_o, bif.bus_sel_o);
        else
          bif.bus_data_i = mem_read(bif.bus_addr_o);
      end else begin
        bif.bus_ack_i = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Drives one pipeline request set and plays the pipeline until every requesting side is released.
  task automatic applyStimulus(input string tag, input bit do_if, input logic [31:0] ia,
                               input bit do_mem, input bit we, input logic [3:0] sel,
                               input logic [31:0] ma, input logic [31:0] md,
                               input int if_bus_ops, input int flush_at, input int exp_if_stalls);
    logic [31:0] exp_if;
    logic [31:0] exp_mem;
    bit          if_pend;
    bit          mem_pend;
    int          if_stalls;
    int          cyc;
    @(negedge clk);
    exp_mem = 32'h0;
    if (do_mem) begin
      exp_bus_q.push_back('{ma, we, sel, we ? md : 32'h0});
      if (!we) exp_mem = mem_read(ma);
    end
    for (int i = 0; i < if_bus_ops; i++)
      exp_bus_q.push_back('{ia, 1'b0, 4'hF, 32'h0});
    exp_if          = mem_read(ia);
    bif.if_ce_i     = do_if;
    bif.if_addr_i   = ia;
    bif.mem_ce_i    = do_mem;
    bif.mem_we_i    = we;
    bif.mem_sel_i   = sel;
    bif.mem_addr_i  = ma;
    bif.mem_data_i  = md;
    if_pend   = do_if;
    mem_pend  = do_mem;
    if_stalls = 0;
    cyc       = 0;
    while ((if_pend || mem_pend) && cyc < 200) begin
      #1;
      bif.flush_i = (cyc == flush_at);
      if (if_pend && bif.if_stallreq_o) if_stalls++;
      if (mem_pend && !bif.mem_stallreq_o) begin
        if (!we) checkOutput({tag, "_mem_data"}, bif.mem_data_o, exp_mem);
        bif.mem_ce_i = 1'b0;
        mem_pend     = 1'b0;
      end
      if (if_pend && !bif.if_stallreq_o && !mem_pend) begin
        checkOutput({tag, "_if_data"}, bif.if_data_o, exp_if);
        if (exp_if_stalls >= 0) checkOutput({tag, "_if_stalls"}, if_stalls, exp_if_stalls);
        bif.if_ce_i = 1'b0;
        if_pend     = 1'b0;
      end
      cyc++;
      if (if_pend || mem_pend) @(negedge clk);
    end
    if (if_pend || mem_pend)
      checkOutput({tag, "_release_timeout"}, 32'({if_pend, mem_pend}), 32'h0);
    bif.flush_i  = 1'b0;
    bif.if_ce_i  = 1'b0;
    bif.mem_ce_i = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    bif.flush_i = 1'b1;
    @(negedge clk);
    bif.flush_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst            = 1'b1;
    bif.flush_i    = 1'b0;
    bif.if_ce_i    = 1'b1;
    bif.if_addr_i  = 32'h100;
    bif.mem_ce_i   = 1'b1;
    bif.mem_we_i   = 1'b1;
    bif.mem_sel_i  = 4'hF;
    bif.mem_addr_i = 32'h2000;
    bif.mem_data_i = 32'hFFFF_FFFF;
    bif.bus_ack_i  = 1'b0;
    bif.bus_data_i = 32'h0;
    mem_model[32'h100] = 32'h3C01_0001;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_bus_cyc", 32'(bif.bus_cyc_o), 32'h0);
    checkOutput("rst_bus_we", 32'(bif.bus_we_o), 32'h0);
    checkOutput("rst_bus_sel", 32'(bif.bus_sel_o), 32'h0);
    checkOutput("rst_bus_addr", bif.bus_addr_o, 32'h0);
    checkOutput("rst_bus_data", bif.bus_data_o, 32'h0);
    checkOutput("rst_mem_data", bif.mem_data_o, 32'h0);
    checkOutput("rst_if_data", bif.if_data_o, 32'h0);
    checkOutput("rst_if_stall", 32'(bif.if_stallreq_o), 32'h0);
    checkOutput("rst_mem_stall", 32'(bif.mem_stallreq_o), 32'h0);
    checkOutput("rst_bus_err", 32'(bif.bus_err_o), 32'h0);
    bif.if_ce_i  = 1'b0;
    bif.mem_ce_i = 1'b0;
    rst = 1'b0;

    ack_wait = 2;
    applyStimulus("fetch_100", 1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 1, -1, 4);
    ack_wait = 0;
    applyStimulus("hit_100", 1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 0, -1, 0);
    applyStimulus("both_104", 1, 32'h104, 1, 0, 4'hF, 32'h2000, 32'h0, 1, -1, 5);
    applyStimulus("hit_104_load", 1, 32'h104, 1, 0, 4'hF, 32'h2004, 32'h0, 0, -1, 0);
    applyStimulus("store_104", 0, 32'h104, 1, 1, 4'hF, 32'h104, 32'h1234_5678, 0, -1, -1);
    applyStimulus("refetch_104", 1, 32'h104, 0, 0, 4'h0, 32'h0, 32'h0, 1, -1, 2);
    applyStimulus("store_3000", 0, 32'h0, 1, 1, 4'h3, 32'h3000, 32'hAABB_CCDD, 0, -1, -1);
    applyStimulus("load_3000", 1, 32'h104, 1, 0, 4'hF, 32'h3000, 32'h0, 0, -1, 0);

    ack_wait = 3;
    applyStimulus("flush_200", 1, 32'h200, 0, 0, 4'h0, 32'h0, 32'h0, 2, 1, 10);
    ack_wait = 0;
    pulse_flush();
    applyStimulus("after_flush", 1, 32'h200, 0, 0, 4'h0, 32'h0, 32'h0, 1, -1, 2);

    ack_wait = 1_000_000;
    @(negedge clk);
    exp_bus_q.push_back('{32'h4000, 1'b0, 4'hF, 32'h0});
    bif.mem_ce_i   = 1'b1;
    bif.mem_we_i   = 1'b0;
    bif.mem_sel_i  = 4'hF;
    bif.mem_addr_i = 32'h4000;
`ifdef BUS_ARB_TIMEOUT_EN
    begin
      int busy = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(negedge clk);
        if (bif.bus_cyc_o) busy++;
        if (bif.bus_err_o) seen = 1'b1;
      end
      checkOutput("timeout_busy_cycles", busy, 255);
      checkOutput("timeout_err", 32'(bif.bus_err_o), 32'h1);
      checkOutput("timeout_mem_data", bif.mem_data_o, 32'h0);
      checkOutput("timeout_mem_stall", 32'(bif.mem_stallreq_o), 32'h0);
      bif.mem_ce_i = 1'b0;
      @(negedge clk);
      checkOutput("timeout_err_once", 32'(bif.bus_err_o), 32'h0);
      checkOutput("timeout_cyc_low", 32'(bif.bus_cyc_o), 32'h0);
      @(negedge clk);
      exp_bus_q.push_back('{32'h4004, 1'b0, 4'hF, 32'h0});
      bif.mem_ce_i   = 1'b1;
      bif.mem_addr_i = 32'h4004;
      repeat (3) @(negedge clk);
    end
`else
    repeat (1000) @(negedge clk);
    checkOutput("noack_still_busy", 32'(bif.mem_stallreq_o), 32'h1);
    checkOutput("noack_err", 32'(bif.bus_err_o), 32'h0);
`endif
    checkOutput("abort_cyc_before", 32'(bif.bus_cyc_o), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_cyc_after", 32'(bif.bus_cyc_o), 32'h0);
    checkOutput("abort_mem_stall", 32'(bif.mem_stallreq_o), 32'h0);
    bif.mem_ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ack_wait = 0;

    applyStimulus("post_reset_100", 1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 1, -1, 2);

    repeat (3) @(negedge clk);
    checkOutput("extra_bus_cycles", extra_cycles, 0);
    checkOutput("missing_bus_cycles", exp_bus_q.size(), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
